// File: rtl/tmrx_err_pkg.sv
// Shared types and default constants for the TMR error monitor.
package tmrx_err_pkg;

    localparam int unsigned CNT_W_DEF  = 8;
    localparam int unsigned THRESH_DEF = 4;
    localparam int unsigned WINDOW_DEF = 16;

    // THRESH is at most 255 and WINDOW at most 65535
    localparam int unsigned HITS_W = 8;
    localparam int unsigned WIN_W  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WATCH   = 2'd1,
        REQ     = 2'd2,
        RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/tmrx_err_window.sv
// Observation-window down-counter: load starts a window, run counts it down,
// expire is high while the count sits at zero.
module tmrx_err_window
    import tmrx_err_pkg::*;
#(
    parameter int unsigned WINDOW = WINDOW_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expire_c
);

    logic [WIN_W-1:0] win;

    // Load takes priority over counting; the counter parks at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            win <= '0;
        end else if (load) begin
            win <= WIN_W'(WINDOW - 1);
        end else if (run && (win != '0)) begin
            win <= win - WIN_W'(1);
        end
    end

    assign expire_c = (win == '0);

endmodule

// File: rtl/tmrx_err_monitor.sv
// TMR voter error monitor: counts error events, keeps a sticky flag and
// raises a four-phase scrub request when THRESH events land in one window.
// Optional macro TMRX_ERR_EDGE_EN: count only 0->1 transitions of err_in.
module tmrx_err_monitor
    import tmrx_err_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned THRESH = THRESH_DEF,
    parameter int unsigned WINDOW = WINDOW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             err_in,
    input  logic             clr,
    input  logic             scrub_ack,
    output logic             scrub_req,
    output logic [CNT_W-1:0] err_cnt,
    output logic             sticky
);

    localparam logic [HITS_W:0]  THRESH_V = (HITS_W + 1)'(THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t            state, state_nxt;
    logic [HITS_W-1:0] hits, hits_nxt;
    logic              err_event;
    logic              win_load, win_run, win_expire;
    logic [HITS_W:0]   hits_inc;
    logic              thresh_hit;

`ifdef TMRX_ERR_EDGE_EN
    logic err_prev;

    // Previous err_in sample for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            err_prev <= 1'b0;
        end else begin
            err_prev <= err_in;
        end
    end

    assign err_event = err_in & ~err_prev;
`else
    assign err_event = err_in;
`endif

    tmrx_err_window #(
        .WINDOW (WINDOW)
    ) u_window (
        .clk      (clk),
        .rst      (rst),
        .load     (win_load),
        .run      (win_run),
        .expire_c (win_expire)
    );

    assign hits_inc   = {1'b0, hits} + (HITS_W + 1)'(1);
    assign thresh_hit = err_event && (hits_inc >= THRESH_V);

    // FSM and hit-count registers; scrub_req follows the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hits      <= '0;
            scrub_req <= 1'b0;
        end else begin
            state     <= state_nxt;
            hits      <= hits_nxt;
            scrub_req <= (state_nxt == REQ);
        end
    end

    // Next-state, hit counting and window control
    always_comb begin
        state_nxt = state;
        hits_nxt  = hits;
        win_load  = 1'b0;
        win_run   = 1'b0;
        case (state)
            IDLE: begin
                if (err_event) begin
                    hits_nxt  = HITS_W'(1);
                    win_load  = 1'b1;
                    state_nxt = (THRESH <= 1) ? REQ : WATCH;
                end
            end
            WATCH: begin
                win_run = 1'b1;
                if (err_event) begin
                    hits_nxt = hits_inc[HITS_W-1:0];
                end
                // A threshold hit in the expiry cycle wins over the expiry
                if (thresh_hit) begin
                    state_nxt = REQ;
                end else if (win_expire) begin
                    state_nxt = IDLE;
                    hits_nxt  = '0;
                end
            end
            REQ: begin
                if (scrub_ack) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (!scrub_ack) begin
                    state_nxt = IDLE;
                    hits_nxt  = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                hits_nxt  = '0;
            end
        endcase
    end

    // Lifetime counter and sticky flag; an event beats a coincident clear
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
            sticky  <= 1'b0;
        end else if (err_event) begin
            sticky <= 1'b1;
            if (clr) begin
                err_cnt <= CNT_W'(1);
            end else if (err_cnt != CNT_MAX) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end else if (clr) begin
            err_cnt <= '0;
            sticky  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tmrx_err_monitor.sv
// Scoreboard bench for tmrx_err_monitor: a default instance and a CNT_W=2
// instance share stimulus; a reference model queues expected outputs.
module tb_tmrx_err_monitor;

    localparam int THRESH = 4;
    localparam int WINDOW = 16;
    localparam int MAX8   = 255;
    localparam int MAX2   = 3;

    typedef struct {
        logic req;
        int   cnt;
        int   cnt_s;
        logic sticky;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       err_in;
    logic       clr;
    logic       scrub_ack;
    logic       scrub_req, scrub_req_s;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt_s;
    logic       sticky, sticky_s;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    // reference model: handshake phase 0 none, 1 requesting, 2 releasing
    int   m_n;
    int   m_phase;
    logic m_open;
    int   m_end;
    int   m_hits;
    int   m_cnt;
    int   m_cnt_s;
    logic m_sticky;
    logic m_prev;

    tmrx_err_monitor #(.CNT_W(8), .THRESH(THRESH), .WINDOW(WINDOW)) dut (
        .clk       (clk),
        .rst       (rst),
        .err_in    (err_in),
        .clr       (clr),
        .scrub_ack (scrub_ack),
        .scrub_req (scrub_req),
        .err_cnt   (err_cnt),
        .sticky    (sticky)
    );

    tmrx_err_monitor #(.CNT_W(2), .THRESH(THRESH), .WINDOW(WINDOW)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .err_in    (err_in),
        .clr       (clr),
        .scrub_ack (scrub_ack),
        .scrub_req (scrub_req_s),
        .err_cnt   (err_cnt_s),
        .sticky    (sticky_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Expected outputs after the edge that samples these inputs
    task automatic model(input logic r, input logic e, input logic c, input logic a);
        logic ev;
        exp_t x;
        ev = e;
`ifdef TMRX_ERR_EDGE_EN
        ev = e & ~m_prev;
        m_prev = r ? 1'b0 : e;
`endif
        if (r) begin
            m_cnt = 0; m_cnt_s = 0; m_sticky = 1'b0;
            m_phase = 0; m_open = 1'b0; m_hits = 0;
        end else begin
            if (ev) begin
                m_cnt    = c ? 1 : ((m_cnt < MAX8) ? m_cnt + 1 : MAX8);
                m_cnt_s  = c ? 1 : ((m_cnt_s < MAX2) ? m_cnt_s + 1 : MAX2);
                m_sticky = 1'b1;
            end else if (c) begin
                m_cnt = 0; m_cnt_s = 0; m_sticky = 1'b0;
            end
            if (m_phase == 1) begin
                if (a) m_phase = 2;
            end else if (m_phase == 2) begin
                if (!a) m_phase = 0;
            end else if (m_open) begin
                if (ev) m_hits++;
                if (m_hits >= THRESH) begin
                    m_phase = 1; m_open = 1'b0;
                end else if (m_n >= m_end) begin
                    m_open = 1'b0; m_hits = 0;
                end
            end else if (ev) begin
                m_hits = 1;
                if (m_hits >= THRESH) m_phase = 1;
                else begin
                    m_open = 1'b1;
                    m_end  = m_n + WINDOW;
                end
            end
        end
        m_n++;
        x.req    = (m_phase == 1);
        x.cnt    = m_cnt;
        x.cnt_s  = m_cnt_s;
        x.sticky = m_sticky;
        exp_q.push_back(x);
    endtask

    task automatic step(input logic r, input logic e, input logic c, input logic a);
        @(negedge clk);
        rst = r; err_in = e; clr = c; scrub_ack = a;
        model(r, e, c, a);
    endtask

    task automatic idle(input int n, input logic a);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, a);
    endtask

    // Monitor: compare every queued expectation just after the clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scrub_req", int'(scrub_req), int'(e.req));
                check("err_cnt", int'(err_cnt), e.cnt);
                check("sticky", int'(sticky), int'(e.sticky));
                check("scrub_req_s", int'(scrub_req_s), int'(e.req));
                check("err_cnt_s", int'(err_cnt_s), e.cnt_s);
                check("sticky_s", int'(sticky_s), int'(e.sticky));
            end
        end
    end

    initial begin
        checks = 0; errors = 0;
        m_n = 0; m_phase = 0; m_open = 1'b0; m_end = 0; m_hits = 0;
        m_cnt = 0; m_cnt_s = 0; m_sticky = 1'b0; m_prev = 1'b0;
        rst = 1'b1; err_in = 1'b0; clr = 1'b0; scrub_ack = 1'b0;

        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);

        // four consecutive error cycles, then hold ack low
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b0);
        // handshake: ack high two cycles, then low
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(4, 1'b0);

        // three isolated events then a long idle: window must expire
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            idle(2, 1'b0);
        end
        idle(20, 1'b1);
        idle(2, 1'b0);

        // saturation of the narrow counter, then clear coincident with an event
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        idle(20, 1'b0);

        // pulsed events into REQ, then reset mid-handshake
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle(2, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);

        // err_in held high for ten cycles
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(20, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // randomized traffic with a wandering acknowledge
        begin
            logic a;
            a = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 5) == 0) a = ~a;
                step(($urandom_range(0, 299) == 0),
                     ($urandom_range(0, 99) < 30),
                     ($urandom_range(0, 24) == 0),
                     a);
            end
        end
        idle(2, 1'b0);

        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tmrx_err_monitor.md
TMRX_ERR_MONITOR -- requirements
Module: tmrx_err_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the lifetime error counter.
REQ-002 SHALL have parameter THRESH, default 4: number of error events within one window that triggers a scrub request; legal range 1..255.
REQ-003 SHALL have parameter WINDOW, default 16: length of the observation window in clk cycles; legal range 2..65535.
REQ-004 SHALL use one clock and a reset that is synchronous and active-high: clk  input  1  rising-edge clock.
REQ-005 SHALL provide rst  input  1  synchronous active-high reset.
REQ-006 SHALL provide err_in  input  1  voter mismatch flag, driven by a tmrx_error_sink output.
REQ-007 SHALL provide clr  input  1  single-cycle clear of err_cnt and sticky.
REQ-008 SHALL provide scrub_ack  input  1  four-phase acknowledge from the scrub/reset controller.
REQ-009 SHALL provide scrub_req  output  1  four-phase scrub request.
REQ-010 SHALL provide err_cnt  output  CNT_W  saturating lifetime error-event count.
REQ-011 SHALL provide sticky  output  1  set by any error event, held until clr.

Function
REQ-012 SHALL define an error event as err_in sampled high on a clk edge (level mode; see REQ-026).
REQ-013 SHALL implement FSM states IDLE, WATCH, REQ and RELEASE.
REQ-014 IDLE: an error event SHALL load hits=1 and win=WINDOW-1 and go to WATCH; if THRESH==1, it SHALL go directly to REQ instead.
REQ-015 WATCH: each cycle SHALL decrement win; an error event SHALL increment hits; when hits+1 reaches THRESH, the FSM SHALL go to REQ on that edge.
REQ-016 WATCH: if win==0 and no threshold is reached in the same cycle, the FSM SHALL return to IDLE with hits=0; a threshold hit in the expiry cycle SHALL take priority and go to REQ.
REQ-017 REQ: scrub_req SHALL be 1, registered, and asserted in the cycle after entering REQ; the FSM SHALL remain in REQ until scrub_ack=1, then go to RELEASE.
REQ-018 RELEASE: scrub_req SHALL be 0; the FSM SHALL remain until scrub_ack=0, then go to IDLE with hits=0.
REQ-019 Error events in REQ and RELEASE SHALL update err_cnt and sticky but SHALL NOT affect hits.
REQ-020 err_cnt SHALL increment by 1 per error event and saturate at 2^CNT_W-1 (no wrap).
REQ-021 If clr and an error event occur in the same cycle, err_cnt SHALL become 1 and sticky SHALL become 1 (the event wins).
REQ-022 clr SHALL NOT affect the FSM, hits or scrub_req.
REQ-023 scrub_ack=1 while in IDLE or WATCH SHALL be ignored.

Reset
REQ-024 While rst=1 on a clk edge: state=IDLE, hits=0, win=0, scrub_req=0, err_cnt=0, sticky=0.
REQ-025 Reset asserted mid-handshake (REQ or RELEASE) SHALL drop scrub_req on the following edge without waiting for scrub_ack.

Configuration
REQ-026 SHALL honour the macro TMRX_ERR_EDGE_EN. When defined, an error event SHALL be a 0->1 transition of err_in, using a registered previous value that resets to 0. When undefined, every cycle with err_in=1 SHALL be an event.

Structure
REQ-027 The package tmrx_err_pkg SHALL hold the FSM state typedef (IDLE/WATCH/REQ/RELEASE) and the default constants for CNT_W, THRESH and WINDOW.
REQ-028 The window down-counter with load/expire SHALL be a sub-module, tmrx_err_window; all other logic SHALL be inline.

Verification
REQ-029 Scenario: err_in high for 4 consecutive cycles in level mode, scrub_ack held at 0. Required: scrub_req=1 one cycle after the 4th event; err_cnt=4; sticky=1.
REQ-030 Scenario: 3 isolated events spaced 3 cycles apart, then idle for 20 cycles. Required: no scrub_req; state returns to IDLE after the window expires; err_cnt=3.
REQ-031 Scenario: handshake where scrub_ack rises 5 cycles after scrub_req, then falls 2 cycles later. Required: scrub_req falls on the edge after ack=1; state returns to IDLE on the edge after ack=0.
REQ-032 Scenario: CNT_W=2 with 6 events. Required: err_cnt saturates at 3. Then clr coincident with one event. Required: err_cnt=1 and sticky=1.
REQ-033 Scenario: TMRX_ERR_EDGE_EN defined, err_in held high for 10 cycles. Required: exactly 1 event counted and err_cnt=1.
REQ-034 Scenario: rst pulsed while in REQ. Required: on the next edge scrub_req=0, err_cnt=0, sticky=0 and state=IDLE.
